// File: rtl/mpaddsub_pkg.sv
// ----------------------------------------------------------------------------
// mpaddsub_pkg
// Shared elaboration helpers for the carry-select adder/subtractor.
//   nblk(width, block)  : number of carry-select blocks, ceil(width/block)
//   lastw(width, block) : width of the most-significant (possibly short) block
// ----------------------------------------------------------------------------
package mpaddsub_pkg;

   function automatic int nblk(input int width, input int block);
      return (width + block - 1) / block;
   endfunction

   function automatic int lastw(input int width, input int block);
      return width - (nblk(width, block) - 1) * block;
   endfunction

endpackage

// File: rtl/mpaddsub_cs_csel_block.sv
// ----------------------------------------------------------------------------
// csel_block
// One carry-select slice: produces both candidate sums of a and b, one for an
// incoming carry of 0 and one for an incoming carry of 1, each with its own
// carry out. The real carry is chosen later, one pipeline stage downstream.
// Ports:
//   a, b    in  W  slice operands (b already conditionally inverted)
//   suma    out W  a + b
//   carrya  out 1  carry out of a + b
//   sumb    out W  a + b + 1
//   carryb  out 1  carry out of a + b + 1
// ----------------------------------------------------------------------------
module csel_block
   import mpaddsub_pkg::*;
#(
   parameter int W = 128
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] suma,
   output logic         carrya,
   output logic [W-1:0] sumb,
   output logic         carryb
);

   assign {carrya, suma} = {1'b0, a} + {1'b0, b};
   assign {carryb, sumb} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};

endmodule

// File: rtl/mpaddsub_cs.sv
// ----------------------------------------------------------------------------
// mpaddsub_cs
// Two-stage pipelined carry-select adder/subtractor for wide Montgomery
// operands. Stage 1 registers per-block dual sums; stage 2 resolves the block
// carry chain, selects sums and registers the WIDTH+1 bit result.
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        operands valid
//   in_ready   out  1        operands accepted this cycle when in_valid
//   in_a       in   WIDTH    operand A
//   in_b       in   WIDTH    operand B
//   in_sub     in   1        0: A+B, 1: A-B
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer takes result
//   result     out  WIDTH+1  sum/difference; bit WIDTH = carry / no-borrow
// ----------------------------------------------------------------------------
module mpaddsub_cs
   import mpaddsub_pkg::*;
#(
   parameter int WIDTH = 1027,
   parameter int BLOCK = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   result
);

   localparam int NBLK = nblk(WIDTH, BLOCK);
   localparam int LW   = lastw(WIDTH, BLOCK);
   // With a single block the whole operand is block 0.
   localparam int W0   = (NBLK == 1) ? WIDTH : BLOCK;

   logic             r_s1_valid;
   logic             r_s2_valid;
   logic [WIDTH:0]   r_result;
   logic             w_adv1;
   logic             w_adv2;
   logic [WIDTH-1:0] w_bp;
   logic [W0-1:0]    w_s0;
   logic             w_c0;
   logic [W0-1:0]    r_s0;
   logic             r_c0;
   logic [WIDTH:0]   w_res_next;

   // Stage 2 advances when empty or drained; stage 1 when it can move into stage 2.
   assign w_adv2    = ~r_s2_valid | out_ready;
   assign w_adv1    = ~r_s1_valid | w_adv2;
   assign in_ready  = w_adv1;
   assign out_valid = r_s2_valid;
   assign result    = r_result;

   // Subtraction is A + ~B + 1; the +1 enters as the block-0 carry-in.
   assign w_bp = in_sub ? ~in_b : in_b;
   assign {w_c0, w_s0} = {1'b0, in_a[W0-1:0]} + {1'b0, w_bp[W0-1:0]} + {{W0{1'b0}}, in_sub};

   // Stage-1 block-0 data register (no reset: contents qualified by r_s1_valid).
   always_ff @(posedge clk) begin
      if (w_adv1 && in_valid) begin
         r_s0 <= w_s0;
         r_c0 <= w_c0;
      end
   end

   generate
      if (NBLK > 1) begin : g_upper
         localparam int UW = WIDTH - W0;

         logic [UW-1:0]   w_sa;
         logic [UW-1:0]   w_sb;
         logic [UW-1:0]   r_sa;
         logic [UW-1:0]   r_sb;
         logic [UW-1:0]   w_sel;
         logic [NBLK-1:1] w_ca;
         logic [NBLK-1:1] w_cb;
         logic [NBLK-1:1] r_ca;
         logic [NBLK-1:1] r_cb;
         logic [NBLK:1]   w_cin;

         for (genvar k = 1; k < NBLK; k++) begin : g_blk
            localparam int BW = (k == NBLK - 1) ? LW : BLOCK;
            localparam int LO = k * BLOCK;

            csel_block #(.W(BW)) u_csel (
               .a      (in_a[LO +: BW]),
               .b      (w_bp[LO +: BW]),
               .suma   (w_sa[LO-W0 +: BW]),
               .carrya (w_ca[k]),
               .sumb   (w_sb[LO-W0 +: BW]),
               .carryb (w_cb[k])
            );

            assign w_sel[LO-W0 +: BW] = w_cin[k] ? r_sb[LO-W0 +: BW] : r_sa[LO-W0 +: BW];
         end

         // Stage-1 dual-sum data registers for blocks 1..NBLK-1.
         always_ff @(posedge clk) begin
            if (w_adv1 && in_valid) begin
               r_sa <= w_sa;
               r_sb <= w_sb;
               r_ca <= w_ca;
               r_cb <= w_cb;
            end
         end

         // Ripple the resolved block carries; w_cin[NBLK] is the final carry out.
         always_comb begin
            w_cin    = {NBLK{1'b0}};
            w_cin[1] = r_c0;
            for (int k = 1; k < NBLK; k++) begin
               w_cin[k+1] = w_cin[k] ? r_cb[k] : r_ca[k];
            end
         end

         assign w_res_next = {w_cin[NBLK], w_sel, r_s0};
      end else begin : g_single
         assign w_res_next = {r_c0, r_s0};
      end
   endgenerate

   // Pipeline valid bits and the registered result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_result   <= {(WIDTH+1){1'b0}};
      end else begin
         if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_result <= w_res_next;
            end
         end
         if (w_adv1) begin
            r_s1_valid <= in_valid;
         end
      end
   end

endmodule

// File: tb/tb_mpaddsub_cs.sv
// ----------------------------------------------------------------------------
// tb_mpaddsub_cs
// Self-checking bench: default 1027-bit instance (directed, backpressure,
// reset mid-flight, random stream), plus WIDTH=10/BLOCK=4 and WIDTH=8/BLOCK=8
// instances driven with random streams. Expected results come from a
// plain-arithmetic reference model and per-instance scoreboard queues.
// ----------------------------------------------------------------------------
module tb_mpaddsub_cs;

   localparam int WB = 1027;
   localparam logic [WB:0] ONE = {{WB{1'b0}}, 1'b1};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic          b_iv, b_ir, b_sub, b_ov, b_or;
   logic [WB-1:0] b_a, b_b;
   logic [WB:0]   b_res;

   logic          s_iv, s_ir, s_sub, s_ov, s_or;
   logic [9:0]    s_a, s_b;
   logic [10:0]   s_res;

   logic          t_iv, t_ir, t_sub, t_ov, t_or;
   logic [7:0]    t_a, t_b;
   logic [8:0]    t_res;

   int tests = 0;
   int fails = 0;

   logic [WB:0] q_big[$];
   logic [WB:0] q_s[$];
   logic [WB:0] q_t[$];

   mpaddsub_cs u_big (
      .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_a(b_a), .in_b(b_b),
      .in_sub(b_sub), .out_valid(b_ov), .out_ready(b_or), .result(b_res)
   );

   mpaddsub_cs #(.WIDTH(10), .BLOCK(4)) u_small (
      .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir), .in_a(s_a), .in_b(s_b),
      .in_sub(s_sub), .out_valid(s_ov), .out_ready(s_or), .result(s_res)
   );

   mpaddsub_cs #(.WIDTH(8), .BLOCK(8)) u_tiny (
      .clk(clk), .rst(rst), .in_valid(t_iv), .in_ready(t_ir), .in_a(t_a), .in_b(t_b),
      .in_sub(t_sub), .out_valid(t_ov), .out_ready(t_or), .result(t_res)
   );

   // Reference: exact sum, or modular difference with an A>=B flag at bit w.
   function automatic logic [WB:0] ref_op(input int w, input logic [WB-1:0] a,
                                          input logic [WB-1:0] b, input logic sub);
      logic [WB:0] mask, ea, eb, r;
      mask = (ONE << w) - ONE;
      ea   = {1'b0, a} & mask;
      eb   = {1'b0, b} & mask;
      if (!sub) begin
         r = ea + eb;
      end else begin
         r = (ea - eb) & mask;
         if (ea >= eb) r = r | (ONE << w);
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [WB:0] got, input logic [WB:0] exp);
      int i;
      logic [63:0] gw, ew;
      tests++;
      if (got !== exp) begin
         fails++;
         i = 0;
         while (i < WB && got[i] === exp[i]) i++;
         gw = 64'(got >> i);
         ew = 64'(exp >> i);
         $display("FAIL %s: actual=%h required=%h (64-bit window from bit %0d)", tag, gw, ew, i);
      end
   endtask

   function automatic logic [WB-1:0] rnd_wide();
      logic [WB-1:0] v;
      int k;
      k = $urandom_range(0, 7);
      v = '0;
      for (int i = 0; i < 33; i++) v = {v[WB-33:0], 32'($urandom)};
      case (k)
         0: v = {WB{1'b1}};
         1: v = '0;
         2: begin v = '0; v[$urandom_range(0, WB-1)] = 1'b1; end
         default: ;
      endcase
      return v;
   endfunction

   // Scoreboards: push the model result on accept, pop and compare on drain.
   always @(negedge clk) begin
      if (rst) begin
         q_big.delete();
      end else begin
         if (b_ov && b_or) begin
            if (q_big.size() == 0) check("big_unexpected_out", 1029'(q_big.size()), ONE);
            else check("big_result", b_res, q_big.pop_front());
         end
         if (b_iv && b_ir) q_big.push_back(ref_op(WB, b_a, b_b, b_sub));
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         q_s.delete();
      end else begin
         if (s_ov && s_or) begin
            if (q_s.size() == 0) check("w10_unexpected_out", 1029'(q_s.size()), ONE);
            else check("w10_result", (WB+1)'(s_res), q_s.pop_front());
         end
         if (s_iv && s_ir) q_s.push_back(ref_op(10, WB'(s_a), WB'(s_b), s_sub));
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         q_t.delete();
      end else begin
         if (t_ov && t_or) begin
            if (q_t.size() == 0) check("w8_unexpected_out", 1029'(q_t.size()), ONE);
            else check("w8_result", (WB+1)'(t_res), q_t.pop_front());
         end
         if (t_iv && t_ir) q_t.push_back(ref_op(8, WB'(t_a), WB'(t_b), t_sub));
      end
   end

   // Present one operation and hold it until accepted; leaves in_valid high.
   task automatic b_send(input logic [WB-1:0] a, input logic [WB-1:0] b, input logic sub,
                         input bit rnd_or);
      int n;
      n     = 0;
      b_a   = a;
      b_b   = b;
      b_sub = sub;
      b_iv  = 1'b1;
      if (rnd_or) b_or = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      while (!b_ir && n < 200) begin
         @(posedge clk); #1;
         if (rnd_or) b_or = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         n++;
      end
      if (!b_ir) check("send_timeout", (WB+1)'(b_ir), ONE);
      @(posedge clk); #1;
   endtask

   task automatic b_idle(input int n);
      b_iv = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Single operation into an empty pipe: accepted at once, valid exactly 2 cycles later.
   task automatic b_directed(input string tag, input logic [WB-1:0] a, input logic [WB-1:0] b,
                             input logic sub, input logic [WB:0] exp);
      b_a   = a;
      b_b   = b;
      b_sub = sub;
      b_iv  = 1'b1;
      @(negedge clk); check({tag, "_ready"}, (WB+1)'(b_ir), ONE);
      @(posedge clk); #1;
      b_iv = 1'b0;
      @(negedge clk); check({tag, "_lat1_valid"}, (WB+1)'(b_ov), '0);
      @(negedge clk); check({tag, "_lat2_valid"}, (WB+1)'(b_ov), ONE);
      check({tag, "_res"}, b_res, exp);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [WB-1:0] a1, a2, bb1, bb2, bhalf;
      logic [WB:0]   e1;
      int n;

      rst  = 1'b1;
      b_iv = 1'b0; b_or = 1'b1; b_a = '0; b_b = '0; b_sub = 1'b0;
      s_iv = 1'b0; s_or = 1'b1; s_a = '0; s_b = '0; s_sub = 1'b0;
      t_iv = 1'b0; t_or = 1'b1; t_a = '0; t_b = '0; t_sub = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", (WB+1)'(b_ov), '0);
      check("rst_in_ready", (WB+1)'(b_ir), ONE);
      check("rst_result", b_res, '0);
      @(posedge clk); #1;

      fork
         begin
            b_directed("add_full_carry", {WB{1'b1}}, WB'(1), 1'b0, ONE << WB);
            b_directed("sub_5_7", WB'(5), WB'(7), 1'b1, (ONE << WB) - (WB+1)'(2));
            b_directed("sub_7_7", WB'(7), WB'(7), 1'b1, ONE << WB);
            bhalf = '0; bhalf[WB-1] = 1'b1;
            b_directed("sub_max_half", {WB{1'b1}}, bhalf, 1'b1,
                       (ONE << WB) | ((ONE << (WB-1)) - ONE));

            // Backpressure: fill both stages with out_ready low, stall 3 cycles.
            a1 = rnd_wide(); bb1 = rnd_wide(); a2 = rnd_wide(); bb2 = rnd_wide();
            e1 = ref_op(WB, a1, bb1, 1'b0);
            b_or = 1'b0;
            b_send(a1, bb1, 1'b0, 1'b0);
            b_send(a2, bb2, 1'b1, 1'b0);
            b_iv = 1'b0;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               check("bp_in_ready_low", (WB+1)'(b_ir), '0);
               check("bp_out_valid_hold", (WB+1)'(b_ov), ONE);
               check("bp_result_hold", b_res, e1);
               @(posedge clk); #1;
            end
            b_or = 1'b1;
            b_send(rnd_wide(), rnd_wide(), 1'b1, 1'b0);
            b_send(rnd_wide(), rnd_wide(), 1'b0, 1'b0);
            b_idle(4);
            check("bp_all_drained", (WB+1)'(q_big.size()), '0);

            // Reset with two operations in flight: neither may appear.
            b_or = 1'b0;
            b_send(rnd_wide(), rnd_wide(), 1'b0, 1'b0);
            b_send(rnd_wide(), rnd_wide(), 1'b1, 1'b0);
            b_iv = 1'b0;
            rst  = 1'b1;
            @(posedge clk); #1;
            rst  = 1'b0;
            b_or = 1'b1;
            @(negedge clk);
            check("midrst_out_valid", (WB+1)'(b_ov), '0);
            check("midrst_in_ready", (WB+1)'(b_ir), ONE);
            @(posedge clk); #1;
            b_directed("post_rst_add", WB'(123456), {WB{1'b1}}, 1'b0,
                       ({1'b0, {WB{1'b1}}}) + (WB+1)'(123456));

            // Random stream with random backpressure and mixed add/sub.
            for (int k = 0; k < 300; k++) begin
               a1  = rnd_wide();
               bb1 = ($urandom_range(0, 7) == 0) ? a1 : rnd_wide();
               b_send(a1, bb1, 1'($urandom_range(0, 1)), 1'b1);
               if ($urandom_range(0, 9) == 0) b_idle(1);
            end
            b_iv = 1'b0;
            b_or = 1'b1;
            n = 0;
            while (q_big.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
         end
         begin
            for (int k = 0; k < 5000; k++) begin
               @(posedge clk); #1;
               s_iv  = ($urandom_range(0, 3) != 0);
               s_or  = ($urandom_range(0, 3) != 0);
               s_sub = 1'($urandom_range(0, 1));
               s_a   = ($urandom_range(0, 5) == 0) ? 10'h3FF : 10'($urandom);
               s_b   = ($urandom_range(0, 5) == 0) ? s_a : 10'($urandom);
            end
            @(posedge clk); #1;
            s_iv = 1'b0; s_or = 1'b1;
            repeat (5) begin @(posedge clk); #1; end
         end
         begin
            for (int k = 0; k < 3000; k++) begin
               @(posedge clk); #1;
               t_iv  = ($urandom_range(0, 3) != 0);
               t_or  = ($urandom_range(0, 2) != 0);
               t_sub = 1'($urandom_range(0, 1));
               t_a   = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
               t_b   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            end
            @(posedge clk); #1;
            t_iv = 1'b0; t_or = 1'b1;
            repeat (5) begin @(posedge clk); #1; end
         end
      join

      check("big_final_drain", (WB+1)'(q_big.size()), '0);
      check("w10_final_drain", (WB+1)'(q_s.size()), '0);
      check("w8_final_drain", (WB+1)'(q_t.size()), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
